// File: rtl/mod_arith_pkg.sv
// Shared types and constants for the modular-arithmetic sequencers.
package mod_arith_pkg;

  localparam int unsigned WIDTH       = 256;
  localparam int unsigned SEQ_TIMEOUT = 64;
  localparam int unsigned SEQ_TW      = 7;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1_RUN = 3'd1,
    GAP    = 3'd2,
    P2_RUN = 3'd3,
    RESP   = 3'd4
  } seq_state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_seq_if.sv
// Request/response and shared-adder bus of the add/sub sequencer.
interface mod_addsub_seq_if;
  import mod_arith_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_op;
  word_t req_a;
  word_t req_b;
  word_t mod_p;
  logic  rsp_valid;
  logic  rsp_ready;
  word_t rsp_data;
  logic  rsp_err;
  logic  add_start;
  word_t add_a;
  word_t add_b;
  logic  add_ci;
  word_t add_s;
  logic  add_co;
  logic  add_done;

  // Environment view: requester, response consumer and adder.
  modport master (
    output req_valid, req_op, req_a, req_b, mod_p, rsp_ready,
    output add_s, add_co, add_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  add_start, add_a, add_b, add_ci
  );

  // Sequencer view.
  modport slave (
    input  req_valid, req_op, req_a, req_b, mod_p, rsp_ready,
    input  add_s, add_co, add_done,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output add_start, add_a, add_b, add_ci
  );

endinterface

// File: rtl/mod_addsub_seq_pass_watchdog.sv
// Per-pass cycle counter; term_c_o flags the TIMEOUT-th cycle of a pass.
module pass_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_c_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count starts at 0 in the first pass cycle, so TIMEOUT-1 marks the last allowed one.
  assign term_c_o = en_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mod_addsub_seq.sv
// Two-pass (A +/- B) mod P sequencer driving a shared multi-cycle adder.
module mod_addsub_seq
  import mod_arith_pkg::*;
#(
  parameter int unsigned TIMEOUT = SEQ_TIMEOUT,
  parameter int unsigned TW      = SEQ_TW
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_addsub_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'(IDLE);
  localparam logic [2:0] S_P1   = 3'(P1_RUN);
  localparam logic [2:0] S_GAP  = 3'(GAP);
  localparam logic [2:0] S_P2   = 3'(P2_RUN);
  localparam logic [2:0] S_RESP = 3'(RESP);

  logic [2:0] state_q, state_d;
  word_t      a_q, a_d, b_q, b_d, p_q, p_d, t_q, t_d, res_q, res_d;
  logic       op_q, op_d, c1_q, c1_d, err_q, err_d;

  logic       add_start_q, add_start_d;
  word_t      add_a_q, add_a_d, add_b_q, add_b_d;
  logic       add_ci_q, add_ci_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;

  logic       in_run_c, wdog_clr_c, wdog_term_c;

  pass_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wdog_clr_c),
    .en_i     (in_run_c),
    .term_c_o (wdog_term_c)
  );

  // Next state, datapath registers and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    t_d         = t_q;
    res_d       = res_q;
    op_d        = op_q;
    c1_d        = c1_q;
    err_d       = err_q;
    add_start_d = 1'b0;
    add_a_d     = '0;
    add_b_d     = '0;
    add_ci_d    = 1'b0;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    in_run_c    = (state_q == S_P1) || (state_q == S_P2);
    wdog_clr_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          p_d     = bus.mod_p;
          op_d    = bus.req_op;
          state_d = S_P1;
        end
      end
      S_P1: begin
        if (bus.add_done) begin
          t_d     = bus.add_s;
          c1_d    = bus.add_co;
          state_d = S_GAP;
        end else if (wdog_term_c) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_GAP: begin
        // A subtraction without borrow is already reduced.
        if ((op_q == OP_SUB) && c1_q) begin
          res_d   = t_q;
          state_d = S_RESP;
        end else begin
          state_d = S_P2;
        end
      end
      S_P2: begin
        if (bus.add_done) begin
          if (op_q == OP_ADD) begin
            res_d = (c1_q || bus.add_co) ? bus.add_s : t_q;
          end else begin
            res_d = bus.add_s;
          end
          state_d = S_RESP;
        end else if (wdog_term_c) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          res_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wdog_clr_c = ((state_d == S_P1) && (state_q != S_P1)) ||
                 ((state_d == S_P2) && (state_q != S_P2));

    // Pass 1 forms A+B or A+~B+1; pass 2 forms T-P (add) or T+P (sub).
    if (state_d == S_P1) begin
      add_start_d = 1'b1;
      add_a_d     = a_d;
      add_b_d     = (op_d == OP_SUB) ? ~b_d : b_d;
      add_ci_d    = (op_d == OP_SUB);
    end else if (state_d == S_P2) begin
      add_start_d = 1'b1;
      add_a_d     = t_d;
      add_b_d     = (op_d == OP_ADD) ? ~p_d : p_d;
      add_ci_d    = (op_d == OP_ADD);
    end

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      t_q         <= '0;
      res_q       <= '0;
      op_q        <= 1'b0;
      c1_q        <= 1'b0;
      err_q       <= 1'b0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_ci_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      t_q         <= t_d;
      res_q       <= res_d;
      op_q        <= op_d;
      c1_q        <= c1_d;
      err_q       <= err_d;
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_ci_q    <= add_ci_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = res_q;
  assign bus.rsp_err   = err_q;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_ci    = add_ci_q;

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Directed bench for mod_addsub_seq with an 18-cycle mock adder.
module tb_mod_addsub_seq;
  import mod_arith_pkg::*;

  localparam int LAT = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mod_addsub_seq_if bus ();

  mod_addsub_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Mock adder: restarts whenever add_start is low, done after LAT cycles.
  int unsigned    acnt = 0;
  logic           hang = 1'b0;
  logic [WIDTH:0] full;
  always @(posedge clk) begin
    if (!bus.add_start) acnt <= 0;
    else                acnt <= acnt + 1;
  end
  always_comb full = {1'b0, bus.add_a} + {1'b0, bus.add_b} + (WIDTH+1)'(bus.add_ci);
  assign bus.add_s    = full[WIDTH-1:0];
  assign bus.add_co   = full[WIDTH];
  assign bus.add_done = bus.add_start && !hang && (acnt >= LAT - 1);

  // Cycle counter and add_start edge monitor.
  int   cyc = 0;
  int   rises = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.add_start && !prev_start) begin
      rises    = rises + 1;
      rise_cyc = cyc;
    end
    if (!bus.add_start && prev_start) fall_cyc = cyc;
    prev_start = bus.add_start;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic op, input word_t a, input word_t b, input word_t p,
                         output word_t data, output logic err, output int lat, output int nrise);
    int acc;
    int base;
    @(negedge clk);
    chk("req_ready_before_req", WIDTH'(bus.req_ready), WIDTH'(1));
    base          = rises;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.mod_p     = p;
    @(posedge clk);
    #1;
    acc           = cyc;
    bus.req_valid = 1'b0;
    lat           = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    nrise = rises - base;
    data  = bus.rsp_data;
    err   = bus.rsp_err;
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rsp_valid_dropped"}, WIDTH'(bus.rsp_valid), WIDTH'(0));
    chk({tag, "_req_ready_back"}, WIDTH'(bus.req_ready), WIDTH'(1));
  endtask

  initial begin
    word_t d;
    word_t pbig;
    logic  e;
    int    lat;
    int    nr;
    int    base;
    int    seen;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.mod_p     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", WIDTH'(bus.req_ready), WIDTH'(1));
    chk("rst_rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(0));
    chk("rst_add_start", WIDTH'(bus.add_start), WIDTH'(0));
    chk("rst_rsp_data",  bus.rsp_data, '0);
    chk("rst_add_a",     bus.add_a, '0);
    rst_n = 1'b1;

    // 5 + 7 mod 11 = 1: pass 2 subtracts P without borrow.
    run_req(OP_ADD, 5, 7, 11, d, e, lat, nr);
    chk("add57_data", d, 1);
    chk("add57_err", WIDTH'(e), WIDTH'(0));
    chk("add57_rises", WIDTH'(nr), WIDTH'(2));
    chk("add57_gap_len", WIDTH'(rise_cyc - fall_cyc), WIDTH'(1));
    chk("add57_lat_le40", WIDTH'(lat >= 0 && lat <= 2*LAT + 4), WIDTH'(1));
    consume("add57");

    // 3 + 4 mod 11 = 7: pass 2 borrows, T kept.
    run_req(OP_ADD, 3, 4, 11, d, e, lat, nr);
    chk("add34_data", d, 7);
    chk("add34_rises", WIDTH'(nr), WIDTH'(2));
    consume("add34");

    // 9 - 4 mod 11 = 5: single pass.
    run_req(OP_SUB, 9, 4, 11, d, e, lat, nr);
    chk("sub94_data", d, 5);
    chk("sub94_err", WIDTH'(e), WIDTH'(0));
    chk("sub94_rises", WIDTH'(nr), WIDTH'(1));
    chk("sub94_lat_le21", WIDTH'(lat >= 0 && lat <= LAT + 3), WIDTH'(1));
    consume("sub94");

    // 4 - 9 mod 11 = 6 with backpressure on the response.
    run_req(OP_SUB, 4, 9, 11, d, e, lat, nr);
    chk("sub49_data", d, 6);
    chk("sub49_rises", WIDTH'(nr), WIDTH'(2));
    chk("sub49_gap_len", WIDTH'(rise_cyc - fall_cyc), WIDTH'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sub49_hold_data", bus.rsp_data, 6);
      chk("sub49_hold_valid", WIDTH'(bus.rsp_valid), WIDTH'(1));
      chk("sub49_hold_req_ready", WIDTH'(bus.req_ready), WIDTH'(0));
    end
    consume("sub49");

    // Carry out of pass 1: (P-1)+(P-1) mod P = P-2, P = 2^256-189.
    pbig = '1;
    pbig = pbig - WIDTH'(188);
    run_req(OP_ADD, pbig - WIDTH'(1), pbig - WIDTH'(1), pbig, d, e, lat, nr);
    chk("addbig_data", d, pbig - WIDTH'(2));
    chk("addbig_err", WIDTH'(e), WIDTH'(0));
    chk("addbig_rises", WIDTH'(nr), WIDTH'(2));
    consume("addbig");

    // Adder never finishes: watchdog response after TIMEOUT cycles.
    hang = 1'b1;
    run_req(OP_ADD, 5, 7, 11, d, e, lat, nr);
    chk("wdog_lat", WIDTH'(lat), WIDTH'(SEQ_TIMEOUT));
    chk("wdog_err", WIDTH'(e), WIDTH'(1));
    chk("wdog_data", d, '0);
    chk("wdog_add_start", WIDTH'(bus.add_start), WIDTH'(0));
    chk("wdog_rises", WIDTH'(nr), WIDTH'(1));
    consume("wdog");
    hang = 1'b0;

    // Asynchronous reset in the middle of pass 2 drops the transaction.
    @(negedge clk);
    base          = rises;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADD;
    bus.req_a     = 5;
    bus.req_b     = 7;
    bus.mod_p     = 11;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rises - base >= 2) break;
    end
    chk("rst_mid_p2_reached", WIDTH'(rises - base), WIDTH'(2));
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_add_start", WIDTH'(bus.add_start), WIDTH'(0));
    chk("async_rst_add_a", bus.add_a, '0);
    chk("async_rst_req_ready", WIDTH'(bus.req_ready), WIDTH'(1));
    chk("async_rst_rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("async_rst_no_rsp", WIDTH'(seen), WIDTH'(0));
    chk("async_rst_idle", WIDTH'(bus.req_ready), WIDTH'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
